sram_addr_generator: RTL and testbench

- Sits directly downstream of the AVR command decoder and consumes its registered control levels (snes_mode, counter_n, sreg_en_n, si, oe_n, we_n).
- Builds the cartridge SRAM address: serially shifted in, then post-incremented by counter strobes.
- Muxes SRAM address and strobes between the AVR path and the SNES bus according to snes_mode.
- All AVR-side inputs are already synchronous to avr_clk, so no synchronisers are used.

---
 rtl/sram_addr_generator_pkg.sv | 16 +
 rtl/sram_addr_generator_edge_detect.sv | 28 ++
 rtl/sram_addr_generator.sv | 126 ++++++++++++
 tb/tb_sram_addr_generator.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_addr_generator_pkg.sv
// Shared constants for the cartridge SRAM address generator and the AVR command decoder.
package sram_addr_generator_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 24;
    localparam int unsigned DEF_CNT_WIDTH  = 5;

    // Bus ownership encoding of snes_mode, common with the command decoder
    localparam logic SNES_OWNS = 1'b1;
    localparam logic AVR_OWNS  = 1'b0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/sram_addr_generator_edge_detect.sv
// One-cycle rise/fall detector; the history register resets to IDLE_LEVEL so
// that leaving reset with the input at its idle level never produces an edge.
module edge_detect
    import sram_addr_generator_pkg::*;
#(
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= IDLE_LEVEL;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = ~sig_q & sig_i;
    assign fall_o = sig_q & ~sig_i;

endmodule

// File: rtl/sram_addr_generator.sv
// SRAM address register (serial load + post-increment) and AVR/SNES bus mux.
// Optional macro SRAM_ADDR_AUTO_INC_EN: rising avr_we_n in count mode also increments.
module sram_addr_generator
    import sram_addr_generator_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  avr_clk,
    input  logic                  avr_reset_n,
    input  logic                  avr_snes_mode,
    input  logic                  avr_counter_n,
    input  logic                  avr_sreg_en_n,
    input  logic                  avr_si,
    input  logic                  avr_oe_n,
    input  logic                  avr_we_n,
    input  logic [ADDR_WIDTH-1:0] snes_addr,
    input  logic                  snes_rd_n,
    input  logic                  snes_wr_n,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  addr_loaded
);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(ADDR_WIDTH);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_WIDTH-1:0]    bit_cnt_q, bit_cnt_d;
    logic                    loaded_q, loaded_d;

    logic strobe;
    logic cnt_rise_unused;
    logic snes_owns;
    logic shift_act;
    logic inc_act;

    edge_detect #(.IDLE_LEVEL(1'b1)) u_cnt_edge (
        .clk_i  (avr_clk),
        .rst_ni (avr_reset_n),
        .sig_i  (avr_counter_n),
        .rise_o (cnt_rise_unused),
        .fall_o (strobe)
    );

    assign snes_owns = (avr_snes_mode == SNES_OWNS);

    // Mode comes from the live sreg_en_n, so a strobe coincident with a mode change uses the new mode
    assign shift_act = strobe & ~snes_owns & ~avr_sreg_en_n;

`ifdef SRAM_ADDR_AUTO_INC_EN
    logic we_rise;
    logic we_fall_unused;

    edge_detect #(.IDLE_LEVEL(1'b1)) u_we_edge (
        .clk_i  (avr_clk),
        .rst_ni (avr_reset_n),
        .sig_i  (avr_we_n),
        .rise_o (we_rise),
        .fall_o (we_fall_unused)
    );

    // OR-ing the two sources makes a coincident write-end and strobe a single increment
    assign inc_act = (strobe | we_rise) & ~snes_owns & avr_sreg_en_n;
`else
    assign inc_act = strobe & ~snes_owns & avr_sreg_en_n;
`endif

    always_ff @(posedge avr_clk or negedge avr_reset_n) begin
        if (!avr_reset_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            bit_cnt_q <= '0;
            loaded_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            bit_cnt_q <= bit_cnt_d;
            loaded_q  <= loaded_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        bit_cnt_d = bit_cnt_q;
        loaded_d  = loaded_q;

        case (state_q)
            ST_IDLE: begin
                if (!avr_sreg_en_n) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    loaded_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (avr_sreg_en_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (shift_act) begin
            addr_d = {addr_q[ADDR_WIDTH-2:0], avr_si};
            if (bit_cnt_d != CNT_FULL) begin
                bit_cnt_d = bit_cnt_d + 1'b1;
            end
            if (bit_cnt_d == CNT_FULL) begin
                loaded_d = 1'b1;
            end
        end else if (inc_act) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end
    end

    assign sram_addr   = snes_owns ? snes_addr : addr_q;
    assign sram_oe_n   = ~avr_reset_n | (snes_owns ? snes_rd_n : avr_oe_n);
    assign sram_we_n   = ~avr_reset_n | (snes_owns ? snes_wr_n : (avr_we_n | ~avr_sreg_en_n));
    assign addr_loaded = loaded_q;

endmodule

// File: tb/tb_sram_addr_generator.sv
// Directed bench for sram_addr_generator; expectations follow SRAM_ADDR_AUTO_INC_EN if defined.
module tb_sram_addr_generator;

    logic        clk;
    logic        rst_n;
    logic        snes_mode;
    logic        counter_n;
    logic        sreg_en_n;
    logic        si;
    logic        oe_n;
    logic        we_n;
    logic [23:0] snes_addr;
    logic        snes_rd_n;
    logic        snes_wr_n;
    logic [23:0] sram_addr;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        addr_loaded;

    int          total = 0;
    int          bad   = 0;
    logic [23:0] exp_addr;
    int          shcnt;
    logic [23:0] base;

    sram_addr_generator dut (
        .avr_clk       (clk),
        .avr_reset_n   (rst_n),
        .avr_snes_mode (snes_mode),
        .avr_counter_n (counter_n),
        .avr_sreg_en_n (sreg_en_n),
        .avr_si        (si),
        .avr_oe_n      (oe_n),
        .avr_we_n      (we_n),
        .snes_addr     (snes_addr),
        .snes_rd_n     (snes_rd_n),
        .snes_wr_n     (snes_wr_n),
        .sram_addr     (sram_addr),
        .sram_oe_n     (sram_oe_n),
        .sram_we_n     (sram_we_n),
        .addr_loaded   (addr_loaded)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One strobe per bit, MSB first; counter_n low for one cycle then high for one
    task automatic shift_seq(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            si        = val[i];
            counter_n = 1'b0;
            @(negedge clk);
            counter_n = 1'b1;
            exp_addr  = {exp_addr[22:0], val[i]};
            shcnt++;
            chk("shift_addr", sram_addr, exp_addr);
            chk("shift_loaded", addr_loaded, (shcnt >= 24) ? 1 : 0);
            chk("shift_we_blocked", sram_we_n, 1);
        end
    endtask

    task automatic pulse();
        @(negedge clk);
        counter_n = 1'b0;
        @(negedge clk);
        counter_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; snes_mode = 1'b0; counter_n = 1'b1; sreg_en_n = 1'b1;
        si = 1'b0; oe_n = 1'b0; we_n = 1'b0;
        snes_addr = 24'h0; snes_rd_n = 1'b1; snes_wr_n = 1'b1;
        #2;
        chk("rst_addr", sram_addr, 24'h0);
        chk("rst_loaded", addr_loaded, 0);
        chk("rst_oe", sram_oe_n, 1);
        chk("rst_we", sram_we_n, 1);
        oe_n = 1'b1; we_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Shift 0xC0FFEE with avr_we_n held low
        @(negedge clk);
        sreg_en_n = 1'b0; we_n = 1'b0;
        exp_addr = 24'h0; shcnt = 0;
        shift_seq(32'hC0FFEE, 24);
        chk("shift_c0ffee", sram_addr, 24'hC0FFEE);
        // we_n rising while shifting never increments
        @(negedge clk); we_n = 1'b1;
        @(negedge clk);
        chk("we_edge_in_shift", sram_addr, 24'hC0FFEE);

        // Count wrap
        shift_seq(32'hFFFFFE, 24);
        @(negedge clk); sreg_en_n = 1'b1;
        pulse(); chk("count_1", sram_addr, 24'hFFFFFF);
        pulse(); chk("count_wrap", sram_addr, 24'h000000);
        pulse(); chk("count_3", sram_addr, 24'h000001);
        chk("count_loaded_hold", addr_loaded, 1);
        @(negedge clk); counter_n = 1'b0;
        #1 chk("count_latency", sram_addr, 24'h000001);
        repeat (10) @(negedge clk);
        chk("held_low_once", sram_addr, 24'h000002);
        counter_n = 1'b1;
        @(negedge clk);
        chk("held_low_release", sram_addr, 24'h000002);
        oe_n = 1'b0;
        #1 chk("avr_oe_pass", sram_oe_n, 0);
        oe_n = 1'b1;

        // SNES ownership
        @(negedge clk);
        snes_mode = 1'b1; snes_addr = 24'h7E0010; snes_rd_n = 1'b0;
        repeat (5) pulse();
        chk("snes_addr", sram_addr, 24'h7E0010);
        chk("snes_oe", sram_oe_n, 0);
        chk("snes_we", sram_we_n, 1);
        snes_wr_n = 1'b0;
        #1 chk("snes_we_pass", sram_we_n, 0);
        snes_wr_n = 1'b1; snes_rd_n = 1'b1;
        @(negedge clk); snes_mode = 1'b0;
        #1 chk("snes_restore", sram_addr, 24'h000002);
        chk("snes_restore_oe", sram_oe_n, 1);

        // Re-entry
        @(negedge clk); sreg_en_n = 1'b0;
        exp_addr = 24'h000002; shcnt = 0;
        shift_seq(32'hA5, 8);
        chk("reentry_partial", sram_addr, 24'h0002A5);
        @(negedge clk); sreg_en_n = 1'b1;
        @(negedge clk);
        chk("reentry_left_loaded", addr_loaded, 0);
        sreg_en_n = 1'b0; shcnt = 0;
        shift_seq(32'h3F123456, 30);
        chk("reentry_last24", sram_addr, 24'h123456);
        @(negedge clk); sreg_en_n = 1'b1;
        @(negedge clk);
        chk("loaded_hold_idle", addr_loaded, 1);

        // Write-pulse behaviour at 0x000100
        sreg_en_n = 1'b0;
        exp_addr = 24'h123456; shcnt = 0;
        shift_seq(32'h000100, 24);
        @(negedge clk); sreg_en_n = 1'b1;
        @(negedge clk); we_n = 1'b0;
        #1 chk("avr_we_pass", sram_we_n, 0);
        @(negedge clk); we_n = 1'b1;
        @(negedge clk); we_n = 1'b0;
        @(negedge clk); we_n = 1'b1;
        @(negedge clk);
`ifdef SRAM_ADDR_AUTO_INC_EN
        base = 24'h000102;
`else
        base = 24'h000100;
`endif
        chk("write_pulses", sram_addr, base);
        @(negedge clk); we_n = 1'b0;
        @(negedge clk); we_n = 1'b1; counter_n = 1'b0;
        @(negedge clk); counter_n = 1'b1;
        @(negedge clk);
        chk("coincident_once", sram_addr, base + 24'h1);

        // Reset mid-operation at 0x001234
        sreg_en_n = 1'b0;
        exp_addr = base + 24'h1; shcnt = 0;
        shift_seq(32'h001234, 24);
        @(negedge clk); sreg_en_n = 1'b1;
        @(negedge clk);
        chk("pre_rst_addr", sram_addr, 24'h001234);
        oe_n = 1'b0; we_n = 1'b0;
        #1 chk("pre_rst_we", sram_we_n, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_addr", sram_addr, 24'h0);
        chk("mid_rst_loaded", addr_loaded, 0);
        chk("mid_rst_oe", sram_oe_n, 1);
        chk("mid_rst_we", sram_we_n, 1);
        oe_n = 1'b1; we_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_addr", sram_addr, 24'h0);
        sreg_en_n = 1'b0;
        exp_addr = 24'h0; shcnt = 0;
        shift_seq(32'hABCDEF, 24);
        chk("post_rst_shift", sram_addr, 24'hABCDEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
